// File: rtl/opp_state_decoder_if.sv
// ----------------------------------------------------------------------------
// opp_state_decoder_if
// Bundles the receive-side word strobe, the held-state valid/ready handshake,
// the decoded opponent fields and the diagnostic outputs of opp_state_decoder.
//
// Signals:
//   axiiv        word valid strobe (from receive)
//   axiid[43:0]  raw 44-bit opponent game-state word
//   state_ready  downstream accepts the held state
//   state_valid  held state pending
//   opp_x/opp_y  opponent position (11 bits each)
//   opp_dir      opponent heading in degrees (9 bits)
//   opp_game     opponent game status (3 bits)
//   opp_reset    one-cycle confirmed-reset pulse
//   link_up      opponent considered alive
//   rx_count / err_count / drop_count  saturating diagnostic counters
//
// Modports:
//   master  word source + state sink (drives axiiv/axiid/state_ready)
//   slave   the decoder itself
// ----------------------------------------------------------------------------
interface opp_state_decoder_if;
  logic        axiiv;
  logic [43:0] axiid;
  logic        state_ready;
  logic        state_valid;
  logic [10:0] opp_x;
  logic [10:0] opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_reset;
  logic        link_up;
  logic [15:0] rx_count;
  logic [15:0] err_count;
  logic [15:0] drop_count;

  modport master (
    output axiiv, axiid, state_ready,
    input  state_valid, opp_x, opp_y, opp_dir, opp_game,
    input  opp_reset, link_up, rx_count, err_count, drop_count
  );

  modport slave (
    input  axiiv, axiid, state_ready,
    output state_valid, opp_x, opp_y, opp_dir, opp_game,
    output opp_reset, link_up, rx_count, err_count, drop_count
  );
endinterface

// File: rtl/opp_state_decoder.sv
// ----------------------------------------------------------------------------
// opp_state_decoder
// Receive-side decoder for the 44-bit opponent game-state word on the RMII
// link (eth_refclk domain). Validates each word, holds the last good state
// behind a valid/ready handshake, converts a repeated reset flag into a single
// confirmed reset pulse, tracks link liveness and keeps saturating counters.
//
// Word layout: [43:33] x, [32] rsvd, [31:21] y, [20] rsvd, [19:11] dir,
//              [10:8] rsvd, [7:5] game, [4] rsvd, [3] reset, [2:0] rsvd.
//
// Parameters:
//   TIMEOUT_CYCLES  idle cycles after the last accepted word before link_up
//                   drops (>= 1)
//   RST_CONFIRM     consecutive accepted reset-flag words needed to fire
//                   opp_reset (1..15)
//
// Ports:
//   eth_clk  50 MHz Ethernet reference clock
//   eth_rst  asynchronous active-high reset
//   bus      opp_state_decoder_if.slave (word in, held state + diagnostics out)
//
// Build option:
//   OPP_DECODER_DEDUP_EN  when defined, an accepted word whose x/y/dir/game
//                         equal the last loaded values does not reload the
//                         holding register or raise state_valid; it still
//                         counts, refreshes liveness and advances the reset run.
// ----------------------------------------------------------------------------
module opp_state_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned RST_CONFIRM    = 3
) (
  input  logic               eth_clk,
  input  logic               eth_rst,
  opp_state_decoder_if.slave bus
);

  localparam int unsigned         IDLE_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDLE_W-1:0]   IDLE_MAX   = IDLE_W'(TIMEOUT_CYCLES);
  localparam logic [3:0]          RUN_TARGET = 4'(RST_CONFIRM);

  // Reset-flag run tracking: ARMED counts consecutive reset words, LOCKED
  // holds after the pulse until a reset-clear word re-arms it.
  typedef enum logic {
    RUN_ARMED,
    RUN_LOCKED
  } run_state_t;

  // --------------------------------------------------------------------------
  // Field extraction and validation
  // --------------------------------------------------------------------------
  logic [10:0] w_x;
  logic [10:0] w_y;
  logic [8:0]  w_dir;
  logic [2:0]  w_game;
  logic        w_rst_flag;
  logic [8:0]  w_rsv;
  logic        w_word_ok;
  logic        w_accept;
  logic        w_reject;
  logic        w_load;
  logic        w_xfer;
  logic        w_fire;
  logic [IDLE_W-1:0] w_idle_next;

  // Registered state
  logic [10:0] r_x;
  logic [10:0] r_y;
  logic [8:0]  r_dir;
  logic [2:0]  r_game;
  logic        r_state_valid;
  logic        r_opp_reset;
  logic        r_link_up;
  logic [15:0] r_rx;
  logic [15:0] r_err;
  logic [15:0] r_drop;
  logic [3:0]  r_run;
  run_state_t  r_run_st;
  logic [IDLE_W-1:0] r_idle;

  always_comb begin
    w_x        = bus.axiid[43:33];
    w_y        = bus.axiid[31:21];
    w_dir      = bus.axiid[19:11];
    w_game     = bus.axiid[7:5];
    w_rst_flag = bus.axiid[3];
    w_rsv      = {bus.axiid[32], bus.axiid[20], bus.axiid[10:8],
                  bus.axiid[4], bus.axiid[2:0]};
    w_word_ok  = (bus.axiid != '0) && (w_dir <= 9'd359) && (w_rsv == '0);
    w_accept   = bus.axiiv && w_word_ok;
    w_reject   = bus.axiiv && !w_word_ok;
  end

  // --------------------------------------------------------------------------
  // Load decision (optionally suppressing unchanged states)
  // --------------------------------------------------------------------------
`ifdef OPP_DECODER_DEDUP_EN
  // r_has_loaded keeps a legitimately all-zero-field word after reset from
  // being mistaken for a duplicate of the cleared register.
  logic r_has_loaded;
  logic w_dup;

  always_comb begin
    w_dup  = r_has_loaded && ({w_x, w_y, w_dir, w_game} == {r_x, r_y, r_dir, r_game});
    w_load = w_accept && !w_dup;
  end

  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      r_has_loaded <= 1'b0;
    end else if (w_load) begin
      r_has_loaded <= 1'b1;
    end
  end
`else
  always_comb begin
    w_load = w_accept;
  end
`endif

  // --------------------------------------------------------------------------
  // Handshake, reset-run and idle next-state helpers
  // --------------------------------------------------------------------------
  always_comb begin
    w_xfer = r_state_valid && bus.state_ready;

    // Fire only from ARMED; the run counter never exceeds RUN_TARGET there,
    // so the 4-bit increment cannot wrap before the compare.
    w_fire = w_accept && w_rst_flag && (r_run_st == RUN_ARMED) &&
             ((r_run + 4'd1) == RUN_TARGET);

    w_idle_next = r_idle;
    if (r_idle != IDLE_MAX) begin
      w_idle_next = r_idle + IDLE_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  always_ff @(posedge eth_clk or posedge eth_rst) begin
    if (eth_rst) begin
      r_x           <= '0;
      r_y           <= '0;
      r_dir         <= '0;
      r_game        <= '0;
      r_state_valid <= 1'b0;
      r_opp_reset   <= 1'b0;
      r_link_up     <= 1'b0;
      r_rx          <= '0;
      r_err         <= '0;
      r_drop        <= '0;
      r_run         <= '0;
      r_run_st      <= RUN_ARMED;
      r_idle        <= '0;
    end else begin
      r_opp_reset <= w_fire;

      if (w_reject && (r_err != '1)) begin
        r_err <= r_err + 16'd1;
      end

      if (w_accept) begin
        if (r_rx != '1) begin
          r_rx <= r_rx + 16'd1;
        end
        r_idle    <= '0;
        r_link_up <= 1'b1;

        if (w_rst_flag) begin
          if (r_run_st == RUN_ARMED) begin
            r_run <= r_run + 4'd1;
            if (w_fire) begin
              r_run_st <= RUN_LOCKED;
            end
          end
        end else begin
          r_run    <= '0;
          r_run_st <= RUN_ARMED;
        end
      end else begin
        r_idle <= w_idle_next;
        // Drops on the edge where the idle count lands on the limit; an
        // accepted word on that edge takes the branch above and keeps it up.
        if (w_idle_next == IDLE_MAX) begin
          r_link_up <= 1'b0;
        end
      end

      // A load on the handshake edge wins: valid stays high and the old
      // state counts as delivered, not dropped.
      if (w_load) begin
        r_x           <= w_x;
        r_y           <= w_y;
        r_dir         <= w_dir;
        r_game        <= w_game;
        r_state_valid <= 1'b1;
        if (r_state_valid && !bus.state_ready && (r_drop != '1)) begin
          r_drop <= r_drop + 16'd1;
        end
      end else if (w_xfer) begin
        r_state_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs (all registered)
  // --------------------------------------------------------------------------
  assign bus.state_valid = r_state_valid;
  assign bus.opp_x       = r_x;
  assign bus.opp_y       = r_y;
  assign bus.opp_dir     = r_dir;
  assign bus.opp_game    = r_game;
  assign bus.opp_reset   = r_opp_reset;
  assign bus.link_up     = r_link_up;
  assign bus.rx_count    = r_rx;
  assign bus.err_count   = r_err;
  assign bus.drop_count  = r_drop;

endmodule
